ap_ctrl_txn_driver: RTL and testbench

- Synthesizable initiator for the ap_ctrl_hs / ap_ctrl_chain block-level handshake.
- Issues a programmed number of transactions to a downstream HLS kernel by driving ap_start and ap_continue, and consumes its ap_ready and ap_done.
- Measures per-transaction latency, then raises a level `finish` that the simulation dataflow monitors use as their end-of-run signal.
- Sits in the testbench/harness wrapper around the top-level kernel; it also serves as an on-chip exerciser.

---
 rtl/ap_ctrl_txn_pkg.sv | 23 ++
 rtl/ap_ts_fifo.sv | 55 +++++
 rtl/ap_ctrl_txn_driver.sv | 153 +++++++++++++++
 tb/tb_ap_ctrl_txn_driver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_txn_pkg.sv
// Shared types and constants for the ap_ctrl_hs / ap_ctrl_chain transaction driver.
package ap_ctrl_txn_pkg;

   localparam int CNT_W_DEF = 32;

   // lat_min starts here so the first real sample always replaces it
   localparam logic [CNT_W_DEF-1:0] LAT_INIT = '1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      GAP,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] last;
      logic [CNT_W_DEF-1:0] min;
      logic [CNT_W_DEF-1:0] max;
   } lat_stats_t;

endpackage

// File: rtl/ap_ts_fifo.sv
// Start-timestamp FIFO; one entry per transaction started but not yet done.
module ap_ts_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so push is legal even when full
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ap_ctrl_txn_driver.sv
// Block-level handshake initiator: issues N ap_start transactions, accepts dones,
// records per-transaction latency and raises finish when the run is complete.
module ap_ctrl_txn_driver
   import ap_ctrl_txn_pkg::*;
#(
   parameter int CNT_W           = CNT_W_DEF,
   parameter int MAX_OUTSTANDING = 4,
   parameter int GAP_W           = 16,
   parameter int STALL_W         = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_start,
   input  logic [CNT_W-1:0]   cmd_num_trans,
   input  logic [GAP_W-1:0]   cmd_start_gap,
   input  logic [STALL_W-1:0] cmd_cont_stall,
   output logic               ap_start,
   output logic               ap_continue,
   input  logic               ap_ready,
   input  logic               ap_done,
   output logic               busy,
   output logic               finish,
   output logic [CNT_W-1:0]   starts_issued,
   output logic [CNT_W-1:0]   dones_seen,
   output logic [CNT_W-1:0]   lat_last,
   output logic [CNT_W-1:0]   lat_min,
   output logic [CNT_W-1:0]   lat_max,
   output logic [CNT_W-1:0]   total_cycles,
   output logic               err_unmatched
);

   state_t             state, state_nx;
   lat_stats_t         stats;
   logic [CNT_W-1:0]   num_trans;
   logic [GAP_W-1:0]   start_gap, gap_cnt;
   logic [STALL_W-1:0] cont_stall, stall_cnt;
   logic [CNT_W-1:0]   ts_head, lat_new;
   logic               start_req, hs, done_acc, bypass, last_start;
   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

   assign start_req  = (state == ISSUE) && !fifo_full;
   assign ap_start   = start_req;
   assign hs         = start_req && ap_ready;
   assign done_acc   = ap_done && ap_continue && (state != IDLE);
   // a done racing its own start never touches the FIFO
   assign bypass     = done_acc && hs && fifo_empty;
   assign fifo_push  = hs && !bypass;
   assign fifo_pop   = done_acc && !fifo_empty;
   assign lat_new    = bypass ? '0 : total_cycles - ts_head;
   assign last_start = (starts_issued + CNT_W'(1) == num_trans);

   assign lat_last = stats.last;
   assign lat_min  = stats.min;
   assign lat_max  = stats.max;

   ap_ts_fifo #(
      .W     (CNT_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_ts_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .din   (total_cycles),
      .pop   (fifo_pop),
      .dout  (ts_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (cmd_start) state_nx = (cmd_num_trans == '0) ? DONE : ISSUE;
         ISSUE: begin
            if (hs) begin
               if (last_start)            state_nx = DRAIN;
               else if (start_gap != '0)  state_nx = GAP;
            end
         end
         GAP:   if (gap_cnt == GAP_W'(1)) state_nx = ISSUE;
         DRAIN: if (dones_seen == num_trans) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         finish        <= 1'b0;
         ap_continue   <= 1'b1;
         stall_cnt     <= '0;
         gap_cnt       <= '0;
         num_trans     <= '0;
         start_gap     <= '0;
         cont_stall    <= '0;
         starts_issued <= '0;
         dones_seen    <= '0;
         total_cycles  <= '0;
         stats         <= '{last: '0, min: LAT_INIT, max: '0};
         err_unmatched <= 1'b0;
      end else begin
         state <= state_nx;
         if (busy) total_cycles <= total_cycles + CNT_W'(1);

         if (state == IDLE && cmd_start) begin
            num_trans     <= cmd_num_trans;
            start_gap     <= cmd_start_gap;
            cont_stall    <= cmd_cont_stall;
            starts_issued <= '0;
            dones_seen    <= '0;
            total_cycles  <= '0;
            stats         <= '{last: '0, min: LAT_INIT, max: '0};
            err_unmatched <= 1'b0;
            busy          <= 1'b1;
            finish        <= 1'b0;
         end
         if (state == DONE) begin
            busy   <= 1'b0;
            finish <= 1'b1;
         end

         if (hs) begin
            starts_issued <= starts_issued + CNT_W'(1);
            gap_cnt       <= start_gap;
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end

         if (done_acc) begin
            dones_seen <= dones_seen + CNT_W'(1);
            if (fifo_pop || bypass) begin
               stats.last <= lat_new;
               if (lat_new < stats.min) stats.min <= lat_new;
               if (lat_new > stats.max) stats.max <= lat_new;
            end else begin
               err_unmatched <= 1'b1;
            end
         end

         // ap_continue stays low for exactly cont_stall cycles after each accepted done
         if (done_acc && cont_stall != '0) begin
            stall_cnt   <= cont_stall;
            ap_continue <= 1'b0;
         end else if (stall_cnt != '0) begin
            stall_cnt   <= stall_cnt - STALL_W'(1);
            ap_continue <= (stall_cnt == STALL_W'(1));
         end
      end
   end

endmodule

// File: tb/tb_ap_ctrl_txn_driver.sv
// Directed bench with a behavioural pipelined/chain kernel and a latency scoreboard.
module tb_ap_ctrl_txn_driver;

   localparam int MAXO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_start = 1'b0;
   logic [31:0] cmd_num_trans = '0;
   logic [15:0] cmd_start_gap = '0;
   logic [7:0]  cmd_cont_stall = '0;
   logic        ap_start, ap_continue, busy, finish, err_unmatched;
   logic        ap_ready = 1'b0;
   logic        ap_done = 1'b0;
   logic [31:0] starts_issued, dones_seen, lat_last, lat_min, lat_max, total_cycles;

   int checks = 0;
   int errors = 0;

   // kernel configuration, driven by the stimulus block
   int k_lat = 5;
   bit k_ready = 1'b1;
   bit spur = 1'b0;

   // model state, owned by the negedge model block
   int cyc = 0;
   int due_q[$];
   int ts_q[$];
   int gaps_q[$];
   int start_hi, max_out, cont_lo, full_viol, idle_run, n_hs, chk_lat;
   int exp_min, exp_max;
   bit chk_pend;

   ap_ctrl_txn_driver #(.CNT_W(32), .MAX_OUTSTANDING(MAXO), .GAP_W(16), .STALL_W(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .cmd_start      (cmd_start),
      .cmd_num_trans  (cmd_num_trans),
      .cmd_start_gap  (cmd_start_gap),
      .cmd_cont_stall (cmd_cont_stall),
      .ap_start       (ap_start),
      .ap_continue    (ap_continue),
      .ap_ready       (ap_ready),
      .ap_done        (ap_done),
      .busy           (busy),
      .finish         (finish),
      .starts_issued  (starts_issued),
      .dones_seen     (dones_seen),
      .lat_last       (lat_last),
      .lat_min        (lat_min),
      .lat_max        (lat_max),
      .total_cycles   (total_cycles),
      .err_unmatched  (err_unmatched)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Kernel: each start completes k_lat cycles later and holds ap_done until ap_continue.
   always @(negedge clock) begin
      int ts;
      int dummy;
      bit hs, acc;
      if (reset) begin
         due_q.delete();
         ts_q.delete();
         chk_pend = 1'b0;
         ap_done  = 1'b0;
         ap_ready = 1'b0;
      end else begin
         if (chk_pend) check("sb_lat_last", lat_last, chk_lat);
         chk_pend = 1'b0;
         if (cmd_start && !busy) begin
            start_hi = 0; max_out = 0; cont_lo = 0; full_viol = 0;
            idle_run = 0; n_hs = 0; gaps_q.delete();
            exp_min = -1; exp_max = 0;
         end
         ap_ready = k_ready;
         ap_done  = spur || (due_q.size() != 0 && due_q[0] <= cyc);
         if (ap_start) start_hi++;
         if (ap_start && ts_q.size() >= MAXO) full_viol++;
         if (!ap_continue) cont_lo++;
         hs  = ap_start && ap_ready;
         acc = ap_done && ap_continue && busy;
         if (hs) begin
            ts_q.push_back(cyc);
            due_q.push_back(cyc + k_lat);
            if (n_hs != 0) gaps_q.push_back(idle_run);
            n_hs++;
            idle_run = 0;
         end else if (n_hs != 0 && busy && !ap_start) begin
            idle_run++;
         end
         if (acc && !spur && ts_q.size() != 0) begin
            dummy   = due_q.pop_front();
            ts      = ts_q.pop_front();
            chk_lat = cyc - ts;
            chk_pend = 1'b1;
            if ($unsigned(chk_lat) < $unsigned(exp_min)) exp_min = chk_lat;
            if (chk_lat > exp_max) exp_max = chk_lat;
         end
         if (ts_q.size() > max_out) max_out = ts_q.size();
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic start_run(input int n, input int gap, input int stall, input int lat);
      k_lat          = lat;
      cmd_num_trans  = n;
      cmd_start_gap  = 16'(gap);
      cmd_cont_stall = 8'(stall);
      cmd_start      = 1'b1;
      tick(1);
      cmd_start      = 1'b0;
   endtask

   task automatic wait_finish(input int limit, output int waited);
      waited = 0;
      while (!finish && waited < limit) begin
         tick(1);
         waited++;
      end
      check("finish_reached", finish, 1);
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_ap_start"}, ap_start, 0);
      check({pfx, "_ap_continue"}, ap_continue, 1);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_finish"}, finish, 0);
      check({pfx, "_starts"}, starts_issued, 0);
      check({pfx, "_dones"}, dones_seen, 0);
      check({pfx, "_total"}, total_cycles, 0);
      check({pfx, "_lat_last"}, lat_last, 0);
      check({pfx, "_lat_min"}, lat_min, 32'hFFFF_FFFF);
      check({pfx, "_lat_max"}, lat_max, 0);
      check({pfx, "_err"}, err_unmatched, 0);
   endtask

   initial begin
      int w;
      tick(2);
      check_reset_vals("rst");
      reset = 1'b0;
      tick(2);

      // single transaction, latency 5
      start_run(1, 0, 0, 5);
      wait_finish(100, w);
      check("t1_lat_last", lat_last, 5);
      check("t1_lat_min", lat_min, 5);
      check("t1_lat_max", lat_max, 5);
      check("t1_busy", busy, 0);
      check("t1_starts", starts_issued, 1);
      check("t1_dones", dones_seen, 1);
      check("t1_start_cycles", start_hi, 1);
      check("t1_err", err_unmatched, 0);

      // back-to-back, II=1, latency 3
      tick(2);
      start_run(4, 0, 0, 3);
      wait_finish(100, w);
      check("t2_start_cycles", start_hi, 4);
      check("t2_gap_count", gaps_q.size(), 3);
      foreach (gaps_q[i]) check("t2_gap_zero", gaps_q[i], 0);
      check("t2_starts", starts_issued, 4);
      check("t2_dones", dones_seen, 4);
      check("t2_lat_min", lat_min, 3);
      check("t2_lat_max", lat_max, 3);

      // latency 10 exceeds FIFO depth: starts throttle at MAXO outstanding
      tick(2);
      start_run(6, 0, 0, 10);
      wait_finish(300, w);
      check("t3_max_outstanding", max_out, MAXO);
      check("t3_start_while_full", full_viol, 0);
      check("t3_lat_min", lat_min, 10);
      check("t3_lat_max", lat_max, 10);
      check("t3_sb_min", lat_min, exp_min);
      check("t3_starts", starts_issued, 6);

      // gaps and continue stall with a chain kernel
      tick(2);
      start_run(3, 2, 3, 2);
      wait_finish(300, w);
      tick(4);
      check("t4_gap_count", gaps_q.size(), 2);
      foreach (gaps_q[i]) check("t4_gap_two", gaps_q[i], 2);
      check("t4_cont_low", cont_lo, 9);
      check("t4_lat_min", lat_min, 2);
      check("t4_lat_max", lat_max, 4);
      check("t4_sb_min", lat_min, exp_min);
      check("t4_sb_max", lat_max, exp_max);

      // zero transactions
      start_run(0, 0, 0, 5);
      wait_finish(10, w);
      check("t5_finish_latency", w, 1);
      check("t5_start_cycles", start_hi, 0);
      check("t5_busy", busy, 0);
      check("t5_starts", starts_issued, 0);

      // cmd_start while busy is ignored
      tick(2);
      start_run(2, 0, 0, 20);
      tick(5);
      cmd_num_trans = 0;
      cmd_start = 1'b1;
      tick(1);
      cmd_start = 1'b0;
      tick(2);
      check("t5b_busy", busy, 1);
      check("t5b_finish", finish, 0);
      wait_finish(200, w);
      check("t5b_starts", starts_issued, 2);
      check("t5b_dones", dones_seen, 2);
      check("t5b_lat_last", lat_last, 20);

      // spurious done before any handshake
      tick(2);
      k_ready = 1'b0;
      start_run(2, 0, 0, 5);
      tick(2);
      spur = 1'b1;
      tick(1);
      spur = 1'b0;
      check("t6_err", err_unmatched, 1);
      check("t6_dones", dones_seen, 1);
      check("t6_starts", starts_issued, 0);
      check("t6_lat_min", lat_min, 32'hFFFF_FFFF);
      check("t6_lat_max", lat_max, 0);
      k_ready = 1'b1;
      wait_finish(100, w);
      tick(3);
      check("t6_err_sticky", err_unmatched, 1);
      check("t6_starts_after", starts_issued, 2);
      check("t6_dones_after", dones_seen, 3);
      check("t6_lat_last", lat_last, 5);

      // reset in the middle of a run
      tick(2);
      start_run(8, 0, 0, 10);
      tick(6);
      check("t7_busy_pre", busy, 1);
      check("t7_starts_pre", starts_issued, MAXO);
      reset = 1'b1;
      tick(1);
      check_reset_vals("t7");
      reset = 1'b0;
      tick(3);
      check("t7_idle_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
